// File: rtl/led_pulse_stretcher.sv
// led_pulse_stretcher: turns single-cycle event strobes into visible LED blinks, queueing events that arrive mid-blink.
module led_pulse_stretcher #(
  parameter int on_final_value  = 99,
  parameter int off_final_value = 99,
  parameter int pending_width   = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pulse,
  input  logic i_clear,
  output logic o_led,
  output logic o_busy,
  output logic o_drop
);
  localparam int max_final = on_final_value > off_final_value ? on_final_value : off_final_value;
  localparam int cnt_width = max_final > 0 ? $clog2(max_final + 1) : 1;
  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
  state_t r_state, w_state;
  logic [cnt_width-1:0] r_cnt, w_cnt;
  logic [pending_width-1:0] r_pending, w_pending;
  logic w_on_done, w_gap_done, w_launch, w_sat, w_drop;
  always_comb begin
    w_on_done  = r_state == ON && r_cnt == cnt_width'(on_final_value);
    w_gap_done = r_state == GAP && r_cnt == cnt_width'(off_final_value);
    w_launch   = w_gap_done && (r_pending != '0 || i_pulse);
    w_sat      = &r_pending;
    w_state    = i_clear ? IDLE :
                 r_state == IDLE ? (i_pulse ? ON : IDLE) :
                 r_state == ON ? (w_on_done ? GAP : ON) :
                 w_gap_done ? (w_launch ? ON : IDLE) : GAP;
    w_cnt      = (i_clear || r_state == IDLE || w_on_done || w_gap_done) ? '0 : r_cnt + 1'b1;
    w_drop     = !i_clear && r_state != IDLE && i_pulse && !w_launch && w_sat;
    // a pulse coinciding with a replay launch cancels that launch's decrement
    w_pending  = i_clear ? '0 :
                 r_state == IDLE ? r_pending :
                 w_launch ? ((r_pending != '0 && !i_pulse) ? r_pending - 1'b1 : r_pending) :
                 (i_pulse && !w_sat) ? r_pending + 1'b1 : r_pending;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pending <= '0;
      o_led     <= 1'b0;
      o_busy    <= 1'b0;
      o_drop    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_pending <= w_pending;
      o_led     <= w_state == ON;
      o_busy    <= w_state != IDLE;
      o_drop    <= w_drop;
    end
  end
endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb_led_pulse_stretcher: directed scenarios with hand-computed LED/busy/drop traces (on=3, off=1, pending_width=2).
module tb_led_pulse_stretcher;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_pulse = 1'b0;
  logic i_clear = 1'b0;
  logic o_led, o_busy, o_drop;
  int n_checks = 0;
  int n_fail = 0;
  logic [47:0] led_v, busy_v, drop_v;
  led_pulse_stretcher #(.on_final_value(3), .off_final_value(1), .pending_width(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pulse(i_pulse), .i_clear(i_clear),
    .o_led(o_led), .o_busy(o_busy), .o_drop(o_drop)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [47:0] span(input int lo, input int hi);
    logic [47:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction
  function automatic logic [47:0] bits(input int a, input int b = -1, input int c = -1, input int d = -1);
    logic [47:0] m = '0;
    m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    if (d >= 0) m[d] = 1'b1;
    return m;
  endfunction
  task automatic do_reset();
    i_rst = 1'b1;
    i_pulse = 1'b0;
    i_clear = 1'b0;
    #3;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask
  // bit k of each trace holds the output seen during cycle k; inputs at bit k are sampled at the end of cycle k
  task automatic run(input logic [47:0] p, input logic [47:0] c);
    led_v = '0;
    busy_v = '0;
    drop_v = '0;
    for (int k = 0; k < 47; k++) begin
      i_pulse = p[k];
      i_clear = c[k];
      @(posedge i_clk);
      #1;
      led_v[k+1] = o_led;
      busy_v[k+1] = o_busy;
      drop_v[k+1] = o_drop;
    end
    i_pulse = 1'b0;
    i_clear = 1'b0;
  endtask
  initial begin
    #12;
    check("rst_led", 48'(o_led), 48'd0);
    check("rst_busy", 48'(o_busy), 48'd0);
    check("rst_drop", 48'(o_drop), 48'd0);
    do_reset();
    run(bits(10), '0);
    check("single_led", led_v, span(11, 14));
    check("single_busy", busy_v, span(11, 16));
    check("single_drop", drop_v, '0);
    do_reset();
    run(bits(10, 11, 12), '0);
    check("three_led", led_v, span(11, 14) | span(17, 20) | span(23, 26));
    check("three_busy", busy_v, span(11, 28));
    check("three_drop", drop_v, '0);
    do_reset();
    run(span(10, 15), '0);
    check("sat_led", led_v, span(11, 14) | span(17, 20) | span(23, 26) | span(29, 32));
    check("sat_busy", busy_v, span(11, 34));
    check("sat_drop", drop_v, bits(15, 16));
    do_reset();
    run(bits(10, 11, 16), '0);
    check("gapend_led", led_v, span(11, 14) | span(17, 20) | span(23, 26));
    check("gapend_busy", busy_v, span(11, 28));
    check("gapend_drop", drop_v, '0);
    do_reset();
    run(bits(10, 11, 12, 13), bits(13));
    check("clear_led", led_v, span(11, 13));
    check("clear_busy", busy_v, span(11, 13));
    check("clear_drop", drop_v, '0);
    do_reset();
    i_pulse = 1'b1;
    @(posedge i_clk);
    #1;
    i_pulse = 1'b0;
    @(posedge i_clk);
    #1;
    check("pre_rst_led", 48'(o_led), 48'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_led", 48'(o_led), 48'd0);
    check("async_rst_busy", 48'(o_busy), 48'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run(bits(10), '0);
    check("post_rst_led", led_v, span(11, 14));
    check("post_rst_busy", busy_v, span(11, 16));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/led_pulse_stretcher.md
Name: led_pulse_stretcher

Overview:
- Output-side counterpart to the input conditioning path: converts single-cycle event pulses into human-visible LED blinks.
- Typical event sources: UART tx-done, rx-done, parity/framing error.
- Each accepted event produces one distinct blink: a fixed ON time followed by a mandatory OFF gap.
- Events that arrive during a blink are queued in a saturating counter and replayed back-to-back.

Parameters:
- on_final_value, 99, ON terminal count; LED high for on_final_value+1 cycles per blink.
- off_final_value, 99, gap terminal count; LED low for off_final_value+1 cycles after each blink.
- pending_width, 3, width of pending-event counter; saturates at 2^pending_width-1.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_pulse  input  1  event strobe; each high cycle is one event.
- i_clear  input  1  synchronous flush: abort blink, drop pending events.
- o_led  output  1  registered LED drive, active high.
- o_busy  output  1  registered; high whenever state is not IDLE.
- o_drop  output  1  registered single-cycle strobe; an event was discarded because pending was saturated.

Behaviour:
- Reset value of all outputs is 0:
  - Asserting i_rst asynchronously forces state=IDLE, cnt=0, pending=0, o_led=0, o_busy=0, o_drop=0.
  - Deassertion is taken synchronously by the design.
  - Reset mid-blink truncates the blink immediately; pending events are lost.
- cnt width = $clog2(max(on_final_value, off_final_value)+1), minimum 1 bit.
- States: IDLE, ON, GAP.
- IDLE:
  - o_led=0.
  - If i_pulse=1 at an edge: next state ON, cnt=0, o_led=1 from the following cycle (latency 1 clock).
  - pending is unchanged because the event is consumed directly.
- ON:
  - o_led=1; cnt increments each cycle.
  - When cnt==on_final_value: next state GAP, cnt=0, o_led=0.
  - LED is high for exactly on_final_value+1 cycles.
- GAP:
  - o_led=0; cnt increments each cycle.
  - When cnt==off_final_value:
    - If pending>0 or i_pulse=1: next state ON, cnt=0.
    - Otherwise: next state IDLE.
  - LED is low for exactly off_final_value+1 cycles minimum between blinks.
- Pending accounting in ON and GAP (applied every cycle):
  - i_pulse=1 and no replay launch this cycle: pending+1, unless saturated.
  - Replay launch at GAP end with pending>0 and i_pulse=0: pending-1.
  - Replay launch at GAP end with pending>0 and i_pulse=1: pending unchanged (net zero).
  - Launch at GAP end with pending==0 and i_pulse=1: the pulse is consumed directly and pending stays 0.
- Saturation: i_pulse=1 while pending==2^pending_width-1 and no decrement in the same cycle:
  - pending stays saturated.
  - o_drop=1 for exactly the next cycle.
- i_clear=1 at an edge:
  - Next state IDLE, cnt=0, pending=0, o_led=0, o_drop=0.
  - i_clear has priority over i_pulse in the same cycle; that pulse is ignored and not counted as a drop.
- o_busy is registered and equals (next state != IDLE).
  - It rises together with o_led on the first blink.
  - It falls the cycle after GAP completes with nothing pending.
- Wrap-around: cnt never exceeds its terminal count. The terminal compare resets it, so no modulo wrap is visible.
- Back-to-back pulses in IDLE: the first starts the blink; the second, arriving while in ON, is queued.

Test Plan:
(All with on_final_value=3, off_final_value=1, pending_width=2.)
- Single pulse at cycle 10 -> o_led high cycles 11-14, low from 15; o_busy high 11-16, low at 17; o_drop never asserted.
- Three pulses at cycles 10, 11, 12 -> blinks high 11-14, 17-20, 23-26; gaps of 2 low cycles; pending peaks at 2 and returns to 0; o_busy falls at 29.
- Five pulses during the first ON window (pending reaches 3, then 2 more) -> o_drop high one cycle after each of the last two pulses; exactly 4 blinks total.
- i_pulse coincident with the final GAP cycle while pending=1 -> replay starts next cycle; pending remains 1; total blinks = 3.
- i_clear at cycle 13 with pending=2 and i_pulse=1 -> o_led=0 and o_busy=0 at cycle 14; no further blinks; pending=0.
- i_rst asserted mid-ON asynchronously -> o_led=0 immediately without a clock edge; after release, a new pulse yields a normal 4-cycle blink.
